// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams program words into instruction memory, holding the CPU until loaded
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [31:0]           checksum
);

  localparam logic [ADDR_WIDTH:0]   CAP  = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

  state_t state, state_next;
  logic   fire;
  logic   full;

  assign fire = (state == S_LOAD) && in_valid;
  assign full = (word_count == CAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD: begin
        // An overflowing word is dropped even when it carries in_last.
        if (fire) begin
          if (full)         state_next = S_ERROR;
          else if (in_last) state_next = S_DONE;
        end
      end
      S_DONE:  if (start) state_next = S_LOAD;
      S_ERROR: if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_LOAD);
    busy     = (state == S_LOAD);
    done     = (state == S_DONE);
    error    = (state == S_ERROR);
    cpu_hold = (state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      checksum   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (state != S_LOAD && start) begin
        word_count <= '0;
        checksum   <= '0;
      end else if (fire && !full) begin
        mem_we     <= 1'b1;
        mem_addr   <= BASE + word_count[ADDR_WIDTH-1:0];
        mem_wdata  <= in_data;
        word_count <= word_count + (ADDR_WIDTH+1)'(1);
        checksum   <= checksum + 32'(in_data);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader (default and 4-word instances)
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, start0, in_valid0, in_last0, in_ready0;
  logic [31:0] in_data0, mem_wdata0, checksum0;
  logic        mem_we0, cpu_hold0, busy0, done0, error0;
  logic [7:0]  mem_addr0;
  logic [8:0]  word_count0;

  logic        reset1, start1, in_valid1, in_last1, in_ready1;
  logic [31:0] in_data1, mem_wdata1, checksum1;
  logic        mem_we1, cpu_hold1, busy1, done1, error1;
  logic [1:0]  mem_addr1;
  logic [2:0]  word_count1;

  imem_loader dut0 (
    .clk(clk), .reset(reset0), .start(start0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_last(in_last0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0),
    .word_count(word_count0), .checksum(checksum0)
  );

  imem_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .BASE_ADDR(0)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_last(in_last1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1),
    .word_count(word_count1), .checksum(checksum1)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Each write must match the oldest expected entry, including the cycle it lands in.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write0: got addr=%0h data=%0h required no write", mem_addr0, mem_wdata0);
      end else begin
        e = q0.pop_front();
        check("wr0_addr", 64'(mem_addr0), 64'(e.addr));
        check("wr0_data", 64'(mem_wdata0), 64'(e.data));
        check("wr0_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (mem_we1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write1: got addr=%0h data=%0h required no write", mem_addr1, mem_wdata1);
      end else begin
        e = q1.pop_front();
        check("wr1_addr", 64'(mem_addr1), 64'(e.addr));
        check("wr1_data", 64'(mem_wdata1), 64'(e.data));
        check("wr1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input int sel, input logic v, input logic [31:0] d, input logic last);
    if (sel == 0) begin in_valid0 = v; in_data0 = d; in_last0 = last; end
    else          begin in_valid1 = v; in_data1 = d; in_last1 = last; end
  endtask

  task automatic send(input int sel, input logic [31:0] d, input logic last,
                      input logic exp_wr, input logic [7:0] a);
    bit  fired;
    wr_t e;
    fired = 0;
    set_in(sel, 1'b1, d, last);
    for (int i = 0; i < 20 && !fired; i++) begin
      @(negedge clk);
      if (((sel == 0) ? in_ready0 : in_ready1) === 1'b1) begin
        fired = 1;
        if (exp_wr) begin
          e.addr = a; e.data = d; e.cyc = cyc + 1;
          if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
      sync();
    end
    if (!fired) begin
      checks++; failures++;
      $display("FAIL handshake_timeout: got no in_ready required in_ready within 20 cycles");
    end
  endtask

  task automatic idle(input int sel, input int n);
    set_in(sel, 1'b0, 32'h0, 1'b0);
    repeat (n) sync();
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    sync();
    if (sel == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready0), 64'(0));
    check({tag, "_mem_we"},   64'(mem_we0),   64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr0), 64'(0));
    check({tag, "_mem_wdata"},64'(mem_wdata0),64'(0));
    check({tag, "_flags"},    64'({cpu_hold0, busy0, done0, error0}), 64'(4'b1000));
    check({tag, "_count"},    64'(word_count0), 64'(0));
    check({tag, "_checksum"}, 64'(checksum0),  64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before timeout");
    $fatal(1);
  end

  initial begin
    reset0 = 1; start0 = 0; in_valid0 = 0; in_data0 = 0; in_last0 = 0;
    reset1 = 1; start1 = 0; in_valid1 = 0; in_data1 = 0; in_last1 = 0;
    repeat (2) sync();
    @(negedge clk);
    check_reset0("rst");
    sync();
    reset0 = 0; reset1 = 0;

    // IDLE ignores in_valid
    set_in(0, 1'b1, 32'hCAFE0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready0), 64'(0));
      sync();
    end
    idle(0, 1);

    // Basic back-to-back load
    pulse_start(0);
    @(negedge clk);
    check("load_flags", 64'({cpu_hold0, busy0, done0}), 64'(3'b110));
    sync();
    send(0, 32'h20080005, 1'b0, 1'b1, 8'd0);
    send(0, 32'h2009000A, 1'b0, 1'b1, 8'd1);
    send(0, 32'h01095020, 1'b1, 1'b1, 8'd2);
    set_in(0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t1_flags", 64'({cpu_hold0, busy0, done0, error0, in_ready0}), 64'(5'b00100));
    check("t1_count", 64'(word_count0), 64'(3));
    check("t1_checksum", 64'(checksum0), 64'h411A502F);
    sync();
    @(negedge clk);
    check("t1_hold_we", 64'(mem_we0), 64'(0));
    check("t1_hold_addr", 64'(mem_addr0), 64'(2));
    check("t1_hold_data", 64'(mem_wdata0), 64'h01095020);
    sync();

    // Reload with gaps; start pulsed mid-load must not restart addressing
    pulse_start(0);
    @(negedge clk);
    check("reload_clear", 64'({cpu_hold0, done0, word_count0}), 64'({1'b1, 1'b0, 9'd0}));
    sync();
    send(0, 32'h12345678, 1'b0, 1'b1, 8'd0);
    set_in(0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_count1", 64'(word_count0), 64'(1));
    sync();
    pulse_start(0);
    send(0, 32'h0F0F0F0F, 1'b0, 1'b1, 8'd1);
    idle(0, 2);
    send(0, 32'h00000100, 1'b1, 1'b1, 8'd2);
    set_in(0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_done", 64'({done0, cpu_hold0}), 64'(2'b10));
    check("t2_count", 64'(word_count0), 64'(3));
    check("t2_checksum", 64'(checksum0), 64'h21436687);
    sync();

    // Single-word reload after DONE
    pulse_start(0);
    send(0, 32'h0BADF00D, 1'b1, 1'b1, 8'd0);
    set_in(0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t3_count", 64'(word_count0), 64'(1));
    check("t3_checksum", 64'(checksum0), 64'h0BADF00D);
    sync();

    // Checksum wrap
    pulse_start(0);
    send(0, 32'hFFFFFFFF, 1'b0, 1'b1, 8'd0);
    send(0, 32'h00000002, 1'b1, 1'b1, 8'd1);
    set_in(0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t4_checksum", 64'(checksum0), 64'h00000001);
    check("t4_count", 64'(word_count0), 64'(2));
    sync();

    // Reset on the same edge as the second handshake
    pulse_start(0);
    send(0, 32'h55AA55AA, 1'b0, 1'b1, 8'd0);
    set_in(0, 1'b1, 32'h66BB66BB, 1'b0);
    reset0 = 1;
    @(negedge clk);
    check("t6_would_fire", 64'(in_ready0), 64'(1));
    sync();
    reset0 = 0;
    set_in(0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_reset0("t6");
    sync();

    // Overflow on the 4-word instance
    pulse_start(1);
    send(1, 32'hA0000001, 1'b0, 1'b1, 8'd0);
    send(1, 32'hA0000002, 1'b0, 1'b1, 8'd1);
    send(1, 32'hA0000003, 1'b0, 1'b1, 8'd2);
    send(1, 32'hA0000004, 1'b0, 1'b1, 8'd3);
    send(1, 32'hA0000005, 1'b1, 1'b0, 8'd0);
    set_in(1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("ovf_flags", 64'({error1, cpu_hold1, busy1, done1, in_ready1}), 64'(5'b11000));
    check("ovf_count", 64'(word_count1), 64'(4));
    check("ovf_checksum", 64'(checksum1), 64'h8000000A);
    check("ovf_hold_addr", 64'(mem_addr1), 64'(3));
    sync();
    pulse_start(1);
    @(negedge clk);
    check("ovf_restart", 64'({error1, busy1, word_count1}), 64'({1'b0, 1'b1, 3'd0}));
    sync();
    send(1, 32'hDEADBEEF, 1'b1, 1'b1, 8'd0);
    set_in(1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("ovf_reload", 64'({done1, cpu_hold1, word_count1}), 64'({1'b1, 1'b0, 3'd1}));
    sync();

    repeat (3) sync();
    check("q0_drained", 64'(q0.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
